// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one MIPS instruction at a time, decodes it into an
// ALU operation, drives a registered ALU request, captures the combinational
// ALU response one cycle later, and holds it until the consumer takes it.
// Illegal instructions skip the ALU and are reported straight away.

module alu_op_sequencer (
  input  logic        clock,
  input  logic        reset,

  // Request side
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,

  // ALU request (registered)
  output logic [4:0]  alu_OPcode,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [4:0]  alu_shamt,

  // ALU response (combinational from the request)
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow_add,
  input  logic        alu_overflow_sub,

  // Response side
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_exc_ovf,
  output logic        out_exc_ill
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StResp
  } state_e;

  // Which ALU overflow flag becomes the architectural exception.
  typedef enum logic [1:0] {
    OvfNone,
    OvfAdd,
    OvfSub
  } ovf_sel_e;

  // ALU operation codes
  localparam logic [4:0] OpAdd  = 5'b00000;
  localparam logic [4:0] OpSub  = 5'b00001;
  localparam logic [4:0] OpMult = 5'b00010;
  localparam logic [4:0] OpDiv  = 5'b00011;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpXor  = 5'b00111;
  localparam logic [4:0] OpSll  = 5'b01000;
  localparam logic [4:0] OpSrl  = 5'b01001;
  localparam logic [4:0] OpSlt  = 5'b01010;
  localparam logic [4:0] OpBeq  = 5'b01100;
  localparam logic [4:0] OpBne  = 5'b01111;

  // MIPS primary opcodes
  localparam logic [5:0] MipsRType = 6'b000000;
  localparam logic [5:0] MipsAddi  = 6'b001000;
  localparam logic [5:0] MipsAndi  = 6'b001100;
  localparam logic [5:0] MipsOri   = 6'b001101;
  localparam logic [5:0] MipsSlti  = 6'b001010;
  localparam logic [5:0] MipsBeq   = 6'b000100;
  localparam logic [5:0] MipsBne   = 6'b000101;

  // MIPS R-type function codes
  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnMult = 6'b011000;
  localparam logic [5:0] FnDiv  = 6'b011010;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnXor  = 6'b100110;
  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnSrl  = 6'b000010;
  localparam logic [5:0] FnSlt  = 6'b101010;

  state_e      state_q, state_d;
  logic [4:0]  opcode_q, opcode_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [4:0]  shamt_q, shamt_d;
  ovf_sel_e    ovf_sel_q, ovf_sel_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        exc_ovf_q, exc_ovf_d;
  logic        exc_ill_q, exc_ill_d;

  // Decoder outputs, valid whenever instr/rs_val/rt_val are presented.
  logic        dec_legal;
  logic [4:0]  dec_opcode;
  logic [31:0] dec_op1;
  logic [31:0] dec_op2;
  logic [4:0]  dec_shamt;
  ovf_sel_e    dec_ovf_sel;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  // Register specifiers are resolved outside; only their values arrive here.
  logic unused_reg_fields;
  assign unused_reg_fields = ^instr[25:16];

  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'h0000, instr[15:0]};

  // Instruction decode into ALU opcode, operands and overflow source.
  always_comb begin
    dec_legal   = 1'b1;
    dec_opcode  = OpAdd;
    dec_op1     = rs_val;
    dec_op2     = rt_val;
    dec_shamt   = 5'd0;
    dec_ovf_sel = OvfNone;
    case (instr[31:26])
      MipsRType: begin
        case (instr[5:0])
          FnAdd: begin
            dec_opcode  = OpAdd;
            dec_ovf_sel = OvfAdd;
          end
          FnSub: begin
            dec_opcode  = OpSub;
            dec_ovf_sel = OvfSub;
          end
          FnMult: dec_opcode = OpMult;
          FnDiv:  dec_opcode = OpDiv;
          FnAnd:  dec_opcode = OpAnd;
          FnOr:   dec_opcode = OpOr;
          FnXor:  dec_opcode = OpXor;
          FnSlt:  dec_opcode = OpSlt;
          FnSll, FnSrl: begin
            dec_opcode = (instr[5:0] == FnSll) ? OpSll : OpSrl;
            dec_op1    = rt_val;
            dec_op2    = 32'd0;
            dec_shamt  = instr[10:6];
          end
          default: dec_legal = 1'b0;
        endcase
      end
      MipsAddi: begin
        dec_opcode  = OpAdd;
        dec_op2     = imm_sext;
        dec_ovf_sel = OvfAdd;
      end
      MipsSlti: begin
        dec_opcode = OpSlt;
        dec_op2    = imm_sext;
      end
      MipsAndi: begin
        dec_opcode = OpAnd;
        dec_op2    = imm_zext;
      end
      MipsOri: begin
        dec_opcode = OpOr;
        dec_op2    = imm_zext;
      end
      MipsBeq: dec_opcode = OpBeq;
      MipsBne: dec_opcode = OpBne;
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state and datapath-load logic; everything holds unless a state says otherwise.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    shamt_d   = shamt_q;
    ovf_sel_d = ovf_sel_q;
    result_d  = result_q;
    zero_d    = zero_q;
    exc_ovf_d = exc_ovf_q;
    exc_ill_d = exc_ill_q;
    case (state_q)
      StIdle: begin
        // in_ready is 1 here, so in_valid alone completes the handshake.
        if (in_valid) begin
          if (dec_legal) begin
            opcode_d  = dec_opcode;
            op1_d     = dec_op1;
            op2_d     = dec_op2;
            shamt_d   = dec_shamt;
            ovf_sel_d = dec_ovf_sel;
            state_d   = StIssue;
          end else begin
            // ALU request registers keep their previous contents.
            result_d  = 32'd0;
            zero_d    = 1'b0;
            exc_ovf_d = 1'b0;
            exc_ill_d = 1'b1;
            state_d   = StResp;
          end
        end
      end
      StIssue: begin
        // One cycle for the ALU to settle on the new request.
        state_d = StCapture;
      end
      StCapture: begin
        result_d  = alu_result;
        zero_d    = alu_zero;
        exc_ill_d = 1'b0;
        case (ovf_sel_q)
          OvfAdd:  exc_ovf_d = alu_overflow_add;
          OvfSub:  exc_ovf_d = alu_overflow_sub;
          default: exc_ovf_d = 1'b0;
        endcase
        state_d = StResp;
      end
      StResp: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      opcode_q  <= 5'd0;
      op1_q     <= 32'd0;
      op2_q     <= 32'd0;
      shamt_q   <= 5'd0;
      ovf_sel_q <= OvfNone;
      result_q  <= 32'd0;
      zero_q    <= 1'b0;
      exc_ovf_q <= 1'b0;
      exc_ill_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      shamt_q   <= shamt_d;
      ovf_sel_q <= ovf_sel_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      exc_ovf_q <= exc_ovf_d;
      exc_ill_q <= exc_ill_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StResp);
  assign alu_OPcode  = opcode_q;
  assign alu_op1     = op1_q;
  assign alu_op2     = op2_q;
  assign alu_shamt   = shamt_q;
  assign out_result  = result_q;
  assign out_zero    = zero_q;
  assign out_exc_ovf = exc_ovf_q;
  assign out_exc_ill = exc_ill_q;

endmodule
